pci_init: RTL and testbench
===========================

Name: pci_init

Overview:
- Initiator (bus master) for the team's simplified PCI-style frame/c_be/adbus bus.
- It is the opposite end of the RAM target: it takes a burst request from local logic and drives the address phase, command and write data onto the bus.
- On reads it releases the bus and captures data at a fixed latency.
- It sits between a local controller (DMA or test sequencer) and the shared adbus.

Parameters:
- RD_LAT, 3: cycles from the first read data-phase cycle to the first valid read word on adbus; legal range 1..15.
- CMD_RD, 4'b0110: c_be code for a memory read.
- CMD_WR, 4'b0111: c_be code for a memory write.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req  in  1  start-burst strobe; sampled only in IDLE.
- req_wr  in  1  1 = write burst, 0 = read burst; sampled with req.
- req_addr  in  32  start address; sampled with req.
- req_len  in  8  beat count, 1..255; 0 is treated as 1.
- busy  out  1  high from the cycle after an accepted req until IDLE is re-entered.
- wr_data  in  32  next write word from a first-word-fall-through source.
- wr_pop  out  1  combinational; high in every cycle wr_data is driven on adbus (consumes that word).
- rd_data  out  32  captured read word.
- rd_valid  out  1  one-cycle pulse per captured read beat.
- done  out  1  one-cycle pulse on the cycle IDLE is re-entered after a burst.
- frame  out  1  bus frame, active-low.
- c_be  out  4  bus command.
- adbus  inout  32  address/data; driven only while adbus_oe is high, otherwise high-Z.

Behaviour:
- Reset, registered: frame=1, c_be=0, adbus_oe=0, busy=0, rd_valid=0, done=0, rd_data=0, state=IDLE.
- Reset mid-burst aborts the burst: the bus is released and frame=1 on the next edge, with no done pulse.
- IDLE:
  - frame=1, c_be=0, adbus released.
  - req=1 latches addr, wr, len (0→1) and moves to ADDR.
  - req while busy is ignored.
- ADDR (1 cycle):
  - frame=0, adbus_oe=1, adbus=latched addr, c_be=CMD_WR or CMD_RD.
  - Next state: WDATA if write, else RDATA.
- c_be holds the command through every data phase of the burst.
- WDATA:
  - adbus=wr_data, wr_pop=1, beat counter counts up from 0.
  - frame=0 on beats 0..len-2; frame=1 on the last beat (len-1).
  - After the last beat: next state IDLE, adbus released, done pulses.
  - len=1: the single data beat is driven with frame=1.
- RDATA:
  - adbus_oe=0 from the first data cycle onward.
  - frame=0 for len-1 cycles, then frame=1 until the burst ends.
  - Capture counter waits RD_LAT cycles, then samples adbus on each of len consecutive cycles: rd_data<=adbus and rd_valid=1 on the following cycle.
  - After the len-th capture: next state IDLE, done pulses on the same cycle as the last rd_valid.
- Total burst length:
  - Write: 1 + len cycles.
  - Read: 1 + RD_LAT + len cycles.
- Counters:
  - Beat counter is 8 bits.
  - Latency counter is 4 bits.
  - No address wrap handling: address incrementing is the target's job.
- The initiator never drives adbus in the same cycle as the target: it releases the bus in the cycle right after ADDR on reads.

Optional Feature:
- Macro PCI_INIT_PARITY_EN.
- When defined:
  - Adds output par (1 bit), reset 0.
  - par is registered: ^{adbus_out, c_be} of the previous cycle, valid the cycle after each phase the initiator drives (ADDR and WDATA beats).
  - Read phases give par=0.
- When undefined: the par port and its logic are absent; all other behaviour is identical.

Test Plan:
- Write len=1, addr=0x10, wr_data=0xDEADBEEF:
  - ADDR cycle shows frame=0, adbus=0x10, c_be=0111.
  - Next cycle shows frame=1, adbus=0xDEADBEEF, wr_pop=1.
  - done pulses and busy falls.
- Write len=4, data 1,2,3,4:
  - frame low for ADDR+3 beats, high on beat 4.
  - Exactly 4 wr_pop cycles.
  - Against the RAM target, a read-back returns 1..4.
- Read len=3, RD_LAT=3, target presents 0xA,0xB,0xC from cycle ADDR+4:
  - rd_valid pulses 3 times with rd_data 0xA,0xB,0xC.
  - adbus_oe=0 from ADDR+1.
  - done coincides with the third rd_valid.
- req_len=0 → exactly one beat is issued.
- req pulsed again while busy → ignored; bus trace is unchanged.
- rst=1 during beat 2 of a len=8 write:
  - Next edge: frame=1, adbus high-Z, busy=0, no done.
  - A new req after reset completes normally.
- With PCI_INIT_PARITY_EN, ADDR=0x1 and CMD_WR → par=0 on the following cycle (^{0x1, 0111} = 0).

Source files
------------

// File: rtl/pci_init.sv
// pci_init: bus-master initiator for the frame/c_be/adbus bus; drives address, command and write data.
// Optional parity output `par` is enabled by defining PCI_INIT_PARITY_EN.
module pci_init #(
   parameter int unsigned RD_LAT = 3,
   parameter logic [3:0]  CMD_RD = 4'b0110,
   parameter logic [3:0]  CMD_WR = 4'b0111
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [7:0]  req_len,
   output logic        busy,
   input  logic [31:0] wr_data,
   output logic        wr_pop,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        done,
   output logic        frame,
   output logic [3:0]  c_be,
`ifdef PCI_INIT_PARITY_EN
   output logic        par,
`endif
   inout  wire  [31:0] adbus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ADDR  = 2'd1;
   localparam logic [1:0] S_WDATA = 2'd2;
   localparam logic [1:0] S_RDATA = 2'd3;
   localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

   logic [1:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic        wr_q, wr_d;
   logic [7:0]  last_q, last_d;       // index of the final beat (len-1)
   logic [7:0]  beat_q, beat_d;
   logic [3:0]  lat_q, lat_d;
   logic        lat_done_q, lat_done_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        done_q, done_d;

   logic        adbus_oe;
   logic [31:0] adbus_out;
   logic [8:0]  rd_idx;

   assign busy     = (state_q != S_IDLE);
   assign wr_pop   = (state_q == S_WDATA);
   assign adbus_oe = (state_q == S_ADDR) || (state_q == S_WDATA);
   assign adbus_out = (state_q == S_ADDR) ? addr_q : wr_data;
   assign adbus    = adbus_oe ? adbus_out : 32'bz;
   assign c_be     = (state_q == S_IDLE) ? 4'b0000 : (wr_q ? CMD_WR : CMD_RD);
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign done     = done_q;

   // Cycle number within the read data phase, spanning latency wait and capture.
   assign rd_idx = lat_done_q ? (9'(RD_LAT) + {1'b0, beat_q}) : {5'b0, lat_q};

   always_comb begin
      unique case (state_q)
         S_IDLE:  frame = 1'b1;
         S_ADDR:  frame = 1'b0;
         S_WDATA: frame = (beat_q == last_q);
         default: frame = !(rd_idx < {1'b0, last_q});
      endcase
   end

   always_comb begin
      // NOTE: every next-state signal gets a default here so no path leaves a latch.
      state_d    = state_q;
      addr_d     = addr_q;
      wr_d       = wr_q;
      last_d     = last_q;
      beat_d     = beat_q;
      lat_d      = lat_q;
      lat_done_d = lat_done_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d     = req_addr;
               wr_d       = req_wr;
               last_d     = (req_len == 8'd0) ? 8'd0 : req_len - 8'd1;
               beat_d     = 8'd0;
               lat_d      = 4'd0;
               lat_done_d = 1'b0;
               state_d    = S_ADDR;
            end
         end
         S_ADDR: state_d = wr_q ? S_WDATA : S_RDATA;
         S_WDATA: begin
            beat_d = beat_q + 8'd1;
            if (beat_q == last_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            if (!lat_done_q) begin
               if (lat_q == LAT_LAST) lat_done_d = 1'b1;
               else                   lat_d      = lat_q + 4'd1;
            end else begin
               rd_data_d  = adbus;
               rd_valid_d = 1'b1;
               beat_d     = beat_q + 8'd1;
               if (beat_q == last_q) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= 32'd0;
         wr_q       <= 1'b0;
         last_q     <= 8'd0;
         beat_q     <= 8'd0;
         lat_q      <= 4'd0;
         lat_done_q <= 1'b0;
         rd_data_q  <= 32'd0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wr_q       <= wr_d;
         last_q     <= last_d;
         beat_q     <= beat_d;
         lat_q      <= lat_d;
         lat_done_q <= lat_done_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
      end
   end

`ifdef PCI_INIT_PARITY_EN
   logic par_q;
   assign par = par_q;
   always_ff @(posedge clk) begin
      if (rst) par_q <= 1'b0;
      else     par_q <= adbus_oe ? ^{adbus_out, c_be} : 1'b0;
   end
`endif

endmodule

// File: tb/tb_pci_init.sv
// tb_pci_init: table-driven bursts with a scoreboard for write words and read captures,
// plus hand-written reset-abort sequence.
module tb_pci_init;
   localparam int         RD_LAT = 3;
   localparam logic [3:0] CMD_RD = 4'b0110;
   localparam logic [3:0] CMD_WR = 4'b0111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        req_wr = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [7:0]  req_len = 8'd0;
   logic        busy, wr_pop, rd_valid, done, frame;
   logic [31:0] wr_data, rd_data;
   logic [3:0]  c_be;
   wire  [31:0] adbus;
   logic        tgt_oe = 1'b0;
   logic [31:0] tgt_data = 32'd0;
`ifdef PCI_INIT_PARITY_EN
   logic        par;
`endif

   assign adbus = tgt_oe ? tgt_data : 32'bz;

   pci_init #(.RD_LAT(RD_LAT), .CMD_RD(CMD_RD), .CMD_WR(CMD_WR)) dut (
      .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
      .req_len(req_len), .busy(busy), .wr_data(wr_data), .wr_pop(wr_pop),
      .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .frame(frame),
      .c_be(c_be),
`ifdef PCI_INIT_PARITY_EN
      .par(par),
`endif
      .adbus(adbus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [7:0]  len;
      bit          busy_req;
      int          cycles;
      int          flow;
      int          pops;
      int          vals;
   } vec_t;

   int n_checks = 0;
   int n_pass   = 0;
   int wi       = 0;
   bit pop_pend = 1'b0;
   logic [31:0] wq[$];
   logic [31:0] rq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   function automatic logic [31:0] wsrc(input int i);
      return (i == 0) ? 32'hDEADBEEF : 32'(i);
   endfunction

   // FWFT source: after a consumed word, present the next one and expect it next.
   task automatic advance_wr();
      if (pop_pend) begin
         wi++;
         wr_data = wsrc(wi);
         wq.push_back(wr_data);
         pop_pend = 1'b0;
      end
   endtask

   task automatic run_burst(input vec_t v, input string tag);
      int fl = 0, pops = 0, vals = 0, bad_cbe = 0, bad_rel = 0, bad_data = 0;
      int done_k = -1;
      int L = (v.len == 8'd0) ? 1 : int'(v.len);
      logic [3:0] cmd = v.wr ? CMD_WR : CMD_RD;
      logic [31:0] exp;
      @(posedge clk); #1;
      req = 1'b1; req_wr = v.wr; req_addr = v.addr; req_len = v.len;
      for (int k = 0; k < 300 && done_k < 0; k++) begin
         @(posedge clk); #1;
         req = v.busy_req && (k == 2 || k == 3);
         advance_wr();
         tgt_oe = 1'b0;
         if (!v.wr && k >= 1 && k <= RD_LAT) begin
            tgt_oe = 1'b1; tgt_data = 32'h5A5A_0000 | 32'(k);
         end else if (!v.wr && k > RD_LAT && k <= RD_LAT + L) begin
            tgt_oe = 1'b1; tgt_data = v.addr | 32'(32'hA + k - RD_LAT - 1);
            rq.push_back(tgt_data);
         end
         #1;
         if (k == 0) begin
            check({tag, " addr frame"}, 32'(frame), 32'd0);
            check({tag, " addr adbus"}, adbus, v.addr);
            check({tag, " addr c_be"}, 32'(c_be), 32'(cmd));
            check({tag, " addr busy"}, 32'(busy), 32'd1);
         end
`ifdef PCI_INIT_PARITY_EN
         if (k == 1) check({tag, " par"}, 32'(par), 32'(^{v.addr, cmd}));
`endif
         if (!frame) fl++;
         if (wr_pop) begin
            pops++;
            exp = (wq.size() > 0) ? wq.pop_front() : 32'hX;
            if (adbus !== exp) bad_data++;
            pop_pend = 1'b1;
         end
         if (rd_valid) begin
            vals++;
            exp = (rq.size() > 0) ? rq.pop_front() : 32'hX;
            if (rd_data !== exp) bad_data++;
         end
         if (tgt_oe && adbus !== tgt_data) bad_rel++;
         if (done) begin
            done_k = k;
            check({tag, " busy at done"}, 32'(busy), 32'd0);
         end else if (c_be !== cmd) bad_cbe++;
      end
      tgt_oe = 1'b0;
      req = 1'b0;
      check({tag, " burst length"}, 32'(done_k), 32'(v.cycles));
      check({tag, " frame low cycles"}, 32'(fl), 32'(v.flow));
      check({tag, " wr_pop cycles"}, 32'(pops), 32'(v.pops));
      check({tag, " rd_valid pulses"}, 32'(vals), 32'(v.vals));
      check({tag, " data errors"}, 32'(bad_data), 32'd0);
      check({tag, " c_be hold errors"}, 32'(bad_cbe), 32'd0);
      check({tag, " bus release errors"}, 32'(bad_rel), 32'd0);
      @(posedge clk); #1;
      advance_wr();
      #1;
      check({tag, " idle busy"}, 32'(busy), 32'd0);
      check({tag, " idle frame"}, 32'(frame), 32'd1);
      check({tag, " idle done"}, 32'(done), 32'd0);
      check({tag, " no leftover reads"}, 32'(rq.size()), 32'd0);
   endtask

   vec_t vecs[9];

   initial begin
      vecs[0] = '{1'b1, 32'h10,  8'd1,  1'b0, 2,  1,  1,  0};
      vecs[1] = '{1'b1, 32'h100, 8'd4,  1'b0, 5,  4,  4,  0};
      vecs[2] = '{1'b0, 32'h200, 8'd3,  1'b0, 7,  3,  0,  3};
      vecs[3] = '{1'b1, 32'h300, 8'd0,  1'b0, 2,  1,  1,  0};
      vecs[4] = '{1'b0, 32'h400, 8'd0,  1'b0, 5,  1,  0,  1};
      vecs[5] = '{1'b0, 32'h500, 8'd1,  1'b0, 5,  1,  0,  1};
      vecs[6] = '{1'b1, 32'h600, 8'd16, 1'b0, 17, 16, 16, 0};
      vecs[7] = '{1'b0, 32'h700, 8'd20, 1'b1, 24, 20, 0,  20};
      vecs[8] = '{1'b1, 32'h1,   8'd4,  1'b1, 5,  4,  4,  0};

      wr_data = wsrc(0);
      wq.push_back(wr_data);

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      tgt_oe = 1'b1; tgt_data = 32'h1234_5678;
      #1;
      check("reset frame", 32'(frame), 32'd1);
      check("reset c_be", 32'(c_be), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset rd_valid", 32'(rd_valid), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset rd_data", rd_data, 32'd0);
      check("reset wr_pop", 32'(wr_pop), 32'd0);
      check("reset bus released", adbus, 32'h1234_5678);
`ifdef PCI_INIT_PARITY_EN
      check("reset par", 32'(par), 32'd0);
`endif
      tgt_oe = 1'b0;

      for (int i = 0; i < 9; i++) run_burst(vecs[i], $sformatf("vec%0d", i));

      // Reset asserted during beat 2 of a len=8 write aborts the burst.
      @(posedge clk); #1;
      req = 1'b1; req_wr = 1'b1; req_addr = 32'h900; req_len = 8'd8;
      for (int k = 0; k <= 3; k++) begin
         @(posedge clk); #1;
         req = 1'b0;
         advance_wr();
         #1;
         if (wr_pop) begin
            if (wq.size() > 0) void'(wq.pop_front());
            pop_pend = 1'b1;
         end
      end
      check("abort beat2 frame", 32'(frame), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      advance_wr();
      tgt_oe = 1'b1; tgt_data = 32'hCAFE_F00D;
      #1;
      check("abort frame", 32'(frame), 32'd1);
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort wr_pop", 32'(wr_pop), 32'd0);
      check("abort bus released", adbus, 32'hCAFE_F00D);
      @(posedge clk); #2;
      check("abort no late done", 32'(done), 32'd0);
      tgt_oe = 1'b0;

      run_burst('{1'b1, 32'hA00, 8'd2, 1'b0, 3, 2, 2, 0}, "post-reset write");
      run_burst('{1'b0, 32'hB00, 8'd2, 1'b0, 6, 2, 0, 2}, "post-reset read");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
